rectangle128_skey_reader: RTL and testbench

RECTANGLE128_SKEY_READER -- requirements
Module: rectangle128_skey_reader

---
 rtl/rectangle128_skey_reader.sv | 106 ++++++++++
 tb/tb_rectangle128_skey_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rectangle128_skey_reader.sv
// ============================================================================
// rectangle128_skey_reader: round-key store with an ordered key streamer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rectangle128_skey_reader #(
  parameter int NUM_KEYS = 26
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        flush,
  input  logic        WE,
  input  logic [4:0]  WAddr,
  input  logic [63:0] KeyIn,
  input  logic        Start,
  input  logic        Decrypt,
  output logic        Ready,
  output logic [63:0] RKey,
  output logic        RKeyValid,
  input  logic        RKeyAck,
  output logic [4:0]  RIdx,
  output logic        Busy,
  output logic        Done
);

  localparam logic [4:0] c_LAST_IDX = 5'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_idx, w_idx_nxt;
  logic                  r_desc, w_desc_nxt;
  logic [63:0]           r_keys [NUM_KEYS];
  logic [NUM_KEYS-1:0]   r_mask;
  logic                  w_wr_ok;
  logic                  w_last;

  assign w_wr_ok = WE && flush && ({27'd0, WAddr} < 32'(NUM_KEYS));
  assign w_last  = r_desc ? (r_idx == 5'd0) : (r_idx == c_LAST_IDX);

  // Key store: flush has priority over a same-cycle write.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < NUM_KEYS; i++) r_keys[i] <= '0;
      r_mask <= '0;
    end else if (!flush) begin
      for (int i = 0; i < NUM_KEYS; i++) r_keys[i] <= '0;
      r_mask <= '0;
    end else if (w_wr_ok) begin
      r_keys[WAddr] <= KeyIn;
      r_mask[WAddr] <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_desc  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_desc  <= w_desc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_desc_nxt  = r_desc;
    case (r_state)
      S_IDLE: begin
        if (Start && Ready) begin
          w_idx_nxt   = Decrypt ? c_LAST_IDX : 5'd0;
          w_desc_nxt  = Decrypt;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (RKeyAck) begin
          if (w_last) w_state_nxt = S_DONE;
          else        w_idx_nxt   = r_desc ? (r_idx - 5'd1) : (r_idx + 5'd1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A clear invalidates the store, so any stream in flight is abandoned.
    if (!flush) w_state_nxt = S_IDLE;
  end

  assign Ready     = &r_mask;
  assign RKeyValid = (r_state == S_STREAM);
  assign Busy      = (r_state == S_STREAM);
  assign Done      = (r_state == S_DONE);
  assign RIdx      = r_idx;
  assign RKey      = RKeyValid ? r_keys[r_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rectangle128_skey_reader.sv
// ============================================================================
// tb_rectangle128_skey_reader: directed self-checking bench for the key reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rectangle128_skey_reader;

  localparam int NK = 26;

  logic        Clk, RstN, flush, WE, Start, Decrypt, RKeyAck;
  logic [4:0]  WAddr;
  logic [63:0] KeyIn;
  logic        Ready, RKeyValid, Busy, Done;
  logic [63:0] RKey;
  logic [4:0]  RIdx;

  int n_tests = 0;
  int n_fail  = 0;

  rectangle128_skey_reader #(.NUM_KEYS(NK)) dut (
    .Clk(Clk), .RstN(RstN), .flush(flush), .WE(WE), .WAddr(WAddr),
    .KeyIn(KeyIn), .Start(Start), .Decrypt(Decrypt), .Ready(Ready),
    .RKey(RKey), .RKeyValid(RKeyValid), .RKeyAck(RKeyAck), .RIdx(RIdx),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, RKeyValid, 0);
    chk({tag, "_busy"},  Busy,      0);
    chk({tag, "_done"},  Done,      0);
    chk({tag, "_ready"}, Ready,     0);
    chk({tag, "_rkey"},  RKey,      0);
    chk({tag, "_ridx"},  RIdx,      0);
  endtask

  task automatic write_key(input int addr, input logic [63:0] data);
    WE = 1'b1; WAddr = 5'(addr); KeyIn = data;
    tick();
    WE = 1'b0;
  endtask

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) write_key(i, 64'(i));
  endtask

  // Entry i holds value i, so the expected key equals the expected index.
  task automatic run_stream(input bit desc, input bit toggle);
    Decrypt = desc; Start = 1'b1; RKeyAck = !toggle;
    tick();
    Start = 1'b0;
    for (int k = 0; k < NK; k++) begin
      int e;
      e = desc ? (NK - 1 - k) : k;
      if (toggle) begin
        RKeyAck = 1'b0;
        chk("str_key", RKey, 64'(e));
        chk("str_idx", RIdx, 64'(e));
        tick();
        chk("str_hold_key", RKey, 64'(e));
        chk("str_hold_idx", RIdx, 64'(e));
        RKeyAck = 1'b1;
      end else begin
        chk("str_key", RKey, 64'(e));
        chk("str_idx", RIdx, 64'(e));
        chk("str_valid", RKeyValid, 1);
        chk("str_done_low", Done, 0);
      end
      tick();
    end
    chk("end_done", Done, 1);
    chk("end_valid", RKeyValid, 0);
    chk("end_busy", Busy, 0);
    RKeyAck = 1'b0;
    tick();
    chk("end_done_once", Done, 0);
  endtask

  initial begin
    RstN = 1'b0; flush = 1'b1; WE = 1'b0; WAddr = '0; KeyIn = '0;
    Start = 1'b0; Decrypt = 1'b0; RKeyAck = 1'b0;
    #12;
    chk_all_zero("reset");
    RstN = 1'b1;
    tick();
    chk("post_reset_valid", RKeyValid, 0);
    chk("post_reset_done", Done, 0);

    // Full load, ascending stream with continuous ack.
    load_range(0, NK - 1);
    chk("ready_full", Ready, 1);
    run_stream(1'b0, 1'b0);

    // Descending stream, ack every other cycle.
    run_stream(1'b1, 1'b1);

    // Start outside IDLE is ignored: stream runs normally from index 0.
    Decrypt = 1'b0; Start = 1'b1; RKeyAck = 1'b0;
    tick();
    tick();
    chk("start_in_stream_idx", RIdx, 0);
    Start = 1'b0;

    // Write to the presented entry shows up on RKey the next cycle.
    write_key(0, 64'hDEAD_BEEF_0123_4567);
    chk("live_write_key", RKey, 64'hDEAD_BEEF_0123_4567);
    chk("live_write_idx", RIdx, 0);
    write_key(0, 64'd0);

    // Flush at the third key of an ascending stream.
    RKeyAck = 1'b1;
    tick();
    tick();
    chk("flush_at_key2", RKey, 2);
    flush = 1'b0;
    tick();
    flush = 1'b1;
    chk("flush_valid", RKeyValid, 0);
    chk("flush_busy", Busy, 0);
    chk("flush_ready", Ready, 0);
    chk("flush_done", Done, 0);
    tick();
    chk("flush_no_done", Done, 0);
    RKeyAck = 1'b0;

    // Partial load: Start ignored while not ready.
    load_range(0, NK - 2);
    chk("partial_ready", Ready, 0);
    Start = 1'b1; Decrypt = 1'b0;
    tick();
    Start = 1'b0;
    chk("partial_no_valid", RKeyValid, 0);
    chk("partial_no_busy", Busy, 0);
    write_key(NK - 1, 64'(NK - 1));
    chk("completed_ready", Ready, 1);
    write_key(30, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("oob_ready", Ready, 1);
    chk("oob_no_valid", RKeyValid, 0);
    run_stream(1'b0, 1'b0);

    // Flush beats a same-cycle write; bit 3 must stay clear.
    WE = 1'b1; WAddr = 5'd3; KeyIn = 64'hABC; flush = 1'b0;
    tick();
    WE = 1'b0; flush = 1'b1;
    chk("flush_we_ready", Ready, 0);
    load_range(0, 2);
    load_range(4, NK - 1);
    chk("mask3_clear", Ready, 0);
    write_key(3, 64'd3);
    chk("mask3_set", Ready, 1);

    // Asynchronous reset mid-stream.
    Decrypt = 1'b0; Start = 1'b1; RKeyAck = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("pre_rst_key", RKey, 1);
    #2;
    RstN = 1'b0;
    #1;
    chk_all_zero("async_rst");
    RKeyAck = 1'b0;
    #3;
    RstN = 1'b1;
    tick();
    chk("rst_rel_done", Done, 0);
    chk("rst_rel_valid", RKeyValid, 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("rst_start_ignored", RKeyValid, 0);
    chk("rst_ready", Ready, 0);
    load_range(0, NK - 1);
    chk("rst_reload_ready", Ready, 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("rst_reload_start", RKeyValid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
